// File: rtl/audio_dac_feeder_pkg.sv
// Shared types and constants for the audio DAC feeder slice.
// Sample width, DAC midscale code and the feeder state encoding.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        RAMP,
        MUTED
    } feederState_t;

endpackage

// File: rtl/audio_dac_feeder_if.sv
// PCM producer handshake: s_data/s_valid from producer, s_ready back.
// master = producer side, slave = feeder side.
interface audio_dac_feeder_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with push/pop/flush, full/empty and level.
// Ports: Clk, Reset_n, push, pop, flush, wrData -> head, full, empty, level.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [SAMPLE_W-1:0] wrData,
    output logic [SAMPLE_W-1:0] head,
    output logic                full,
    output logic                empty,
    output logic [FIFO_AW:0]    level
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]  wrPtr;
    logic [FIFO_AW-1:0]  rdPtr;
    logic                doPush;
    logic                doPop;

    // Level can only reach DEPTH, so its MSB alone marks full.
    assign full   = level[FIFO_AW];
    assign empty  = (level == '0);
    assign head   = mem[rdPtr];
    // Flush wins over both ports so a dropped cycle leaves no residue.
    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;

    always_ff @(posedge Clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_feeder.sv
// Sample-rate scheduler feeding the 8-bit sigma-delta DAC with soft mute.
// Ports: Clk, Reset_n, enable, mute, sIf (PCM handshake), dac_sample,
// sample_tick, underrun, fifo_level.
module audio_dac_feeder
    import audio_pkg::*;
#(
    parameter int CLK_DIV     = 3125,
    parameter int FIFO_AW     = 4,
    parameter int PRIME_LEVEL = 8,
    parameter int RAMP_STEP   = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                enable,
    input  logic                mute,
    audio_dac_feeder_if.slave   sIf,
    output logic [SAMPLE_W-1:0] dac_sample,
    output logic                sample_tick,
    output logic                underrun,
    output logic [FIFO_AW:0]    fifo_level
);

    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] PRIME_L = (FIFO_AW + 1)'(PRIME_LEVEL);
    localparam logic [SAMPLE_W:0] STEP9 = (SAMPLE_W + 1)'(RAMP_STEP);
    localparam logic [SAMPLE_W:0] MID9 = {1'b0, MIDSCALE};

    feederState_t        state;
    logic [15:0]         tickCnt;
    logic                tick;
    logic                push;
    logic                pop;
    logic                flush;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [SAMPLE_W-1:0] fifoHead;
    logic [SAMPLE_W-1:0] rampNext;

    // One ramp step toward midscale; 9-bit math, clamps at midscale.
    function automatic logic [SAMPLE_W-1:0] rampTo(
        input logic [SAMPLE_W-1:0] cur
    );
        logic [SAMPLE_W:0] val;
        if (cur > MIDSCALE) begin
            val = {1'b0, cur} - STEP9;
            return (val <= MID9) ? MIDSCALE : val[SAMPLE_W-1:0];
        end
        val = {1'b0, cur} + STEP9;
        return (val >= MID9) ? MIDSCALE : val[SAMPLE_W-1:0];
    endfunction

    assign tick        = (state != IDLE) && (tickCnt == TICK_LAST);
    assign sample_tick = tick;
    assign underrun    = tick && (state == RUN) && fifoEmpty;
    assign sIf.s_ready = (state != IDLE) && !fifoFull;
    assign push        = sIf.s_valid && sIf.s_ready;
    // RAMP and MUTED drain too, keeping the stream in step with time.
    assign pop   = tick && enable &&
                   (state == RUN || state == RAMP || state == MUTED);
    assign flush = !enable || (state == IDLE);
    assign rampNext = rampTo(dac_sample);

    audio_sample_fifo #(
        .FIFO_AW (FIFO_AW)
    ) uFifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wrData  (sIf.s_data),
        .head    (fifoHead),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (fifo_level)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tickCnt    <= '0;
            dac_sample <= MIDSCALE;
        end else if (!enable) begin
            state      <= IDLE;
            tickCnt    <= '0;
            dac_sample <= MIDSCALE;
        end else begin
            if (state == IDLE || tick) begin
                tickCnt <= '0;
            end else begin
                tickCnt <= tickCnt + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    state      <= PRIME;
                    dac_sample <= MIDSCALE;
                end
                PRIME: begin
                    if (fifo_level >= PRIME_L) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (tick && !fifoEmpty) begin
                        dac_sample <= fifoHead;
                    end
                    if (mute) begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (!mute) begin
                        state <= RUN;
                    end else if (tick) begin
                        dac_sample <= rampNext;
                        if (rampNext == MIDSCALE) begin
                            state <= MUTED;
                        end
                    end
                end
                MUTED: begin
                    dac_sample <= MIDSCALE;
                    if (!mute) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Self-checking bench for audio_dac_feeder against a queue-based model.
// Directed scenarios followed by a randomized run.
module tb_audio_dac_feeder;

    localparam int DIV  = 4;
    localparam int DEPTH = 16;
    localparam int PRIM = 8;
    localparam int STEP = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       enable;
    logic       mute;
    logic [7:0] dac_sample;
    logic       sample_tick;
    logic       underrun;
    logic [4:0] fifo_level;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 prime, 2 run, 3 ramp, 4 muted
    int         mMode;
    int         mCnt;
    int         mDac;
    logic [7:0] q[$];

    audio_dac_feeder_if bus ();

    audio_dac_feeder #(
        .CLK_DIV     (DIV),
        .FIFO_AW     (4),
        .PRIME_LEVEL (PRIM),
        .RAMP_STEP   (STEP)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .enable      (enable),
        .mute        (mute),
        .sIf         (bus),
        .dac_sample  (dac_sample),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mCnt  = 0;
        mDac  = 128;
        q.delete();
    endtask

    function automatic logic expReady();
        return (mMode != 0) && (q.size() < DEPTH);
    endfunction

    function automatic logic expTick();
        return (mMode != 0) && (mCnt == DIV - 1);
    endfunction

    task automatic checkAll();
        logic t;
        t = expTick();
        check("s_ready", 16'(bus.s_ready), 16'(expReady()));
        check("sample_tick", 16'(sample_tick), 16'(t));
        check("underrun", 16'(underrun),
              16'(t && mMode == 2 && q.size() == 0));
        check("dac_sample", 16'(dac_sample), 16'(mDac));
        check("fifo_level", 16'(fifo_level), 16'(q.size()));
    endtask

    task automatic modelEdge(input logic en, input logic mu,
                             input logic v, input logic [7:0] d);
        logic       t;
        logic       rdy;
        int         oldSize;
        logic [7:0] hd;
        t       = expTick();
        rdy     = expReady();
        oldSize = q.size();
        hd      = (oldSize > 0) ? q[0] : 8'h00;
        if (!en) begin
            modelReset();
            return;
        end
        if (t && mMode >= 2 && oldSize > 0) void'(q.pop_front());
        if (v && rdy) q.push_back(d);
        mCnt = (mMode == 0 || mCnt == DIV - 1) ? 0 : mCnt + 1;
        case (mMode)
            0: begin
                mMode = 1;
                mDac  = 128;
            end
            1: if (oldSize >= PRIM) mMode = 2;
            2: begin
                if (t && oldSize > 0) mDac = hd;
                if (mu) mMode = 3;
            end
            3: begin
                if (!mu) mMode = 2;
                else if (t) begin
                    if (mDac > 128)
                        mDac = (mDac - STEP < 128) ? 128 : mDac - STEP;
                    else
                        mDac = (mDac + STEP > 128) ? 128 : mDac + STEP;
                    if (mDac == 128) mMode = 4;
                end
            end
            default: begin
                mDac = 128;
                if (!mu) mMode = 2;
            end
        endcase
    endtask

    // Inputs change at posedge+1; outputs checked at posedge+2.
    task automatic step(input logic en, input logic mu,
                        input logic v, input logic [7:0] d);
        enable      = en;
        mute        = mu;
        bus.s_valid = v;
        bus.s_data  = d;
        #1;
        checkAll();
        @(posedge Clk);
        modelEdge(en, mu, v, d);
        #1;
    endtask

    task automatic idle(input int n, input logic mu);
        for (int i = 0; i < n; i++) step(1'b1, mu, 1'b0, 8'h00);
    endtask

    task automatic pushN(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, val);
    endtask

    task automatic flushTwice();
        step(1'b0, 1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic mu;
        Reset_n     = 1'b0;
        enable      = 1'b0;
        mute        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        modelReset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checkAll();
        Reset_n = 1'b1;

        // Prime with 10..17, play out, then underrun, then a late 55
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
        idle(44, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h55);
        idle(8, 1'b0);

        // Fill to full with continuous pushes
        flushTwice();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 28; i++)
            step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
        idle(6, 1'b0);

        // Ramp down from 8A, then unmute onto C0
        flushTwice();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        pushN(8, 8'h8A);
        idle(6, 1'b0);
        idle(40, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hC0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(8, 1'b0);

        // Ramp up from 7E must land exactly on midscale
        flushTwice();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        pushN(8, 8'h7E);
        idle(6, 1'b0);
        idle(12, 1'b1);

        // Drop enable mid-period with samples queued
        flushTwice();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        pushN(9, 8'h33);
        idle(6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h44);
        idle(1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        idle(1, 1'b0);

        // Async reset while ramping down from FF
        pushN(8, 8'hFF);
        idle(8, 1'b0);
        idle(10, 1'b1);
        Reset_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Randomized traffic
        mu = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) mu = ~mu;
            step(($urandom_range(149) != 0), mu,
                 1'($urandom_range(1)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
